// File: rtl/exp4_trena.sv
// Ultrasonic tape-measure controller: triggers an HC-SR04-style sensor, times the echo
// in centimetres (3 BCD digits), shows it on 7-segment displays and sends "HTU#" over UART.

module exp4_trena_echo (
    input  logic clock,
    input  logic reset,
    input  logic echo,
    output logic level,
    output logic rise
);
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= echo;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~prev_q;
endmodule

module exp4_trena_bcd (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [11:0] value
);
    logic [11:0] value_q, value_d;

    // Three-digit decimal counter that sticks at 999 instead of wrapping.
    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = 12'h000;
        end else if (inc && value_q != 12'h999) begin
            if (value_q[3:0] != 4'd9) begin
                value_d[3:0] = value_q[3:0] + 4'd1;
            end else begin
                value_d[3:0] = 4'd0;
                if (value_q[7:4] != 4'd9) begin
                    value_d[7:4] = value_q[7:4] + 4'd1;
                end else begin
                    value_d[7:4]  = 4'd0;
                    value_d[11:8] = value_q[11:8] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) value_q <= 12'h000;
        else       value_q <= value_d;
    end

    assign value = value_q;
endmodule

module exp4_trena_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] data,
    output logic       tx,
    output logic       done
);
    localparam int BW = $clog2(BAUD_DIV + 1);

    logic [BW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [8:0]    shift_q;
    logic          busy_q, tx_q, done_q;

    // Frame: start, 7 data bits LSB first, odd parity, stop; done pulses after the stop bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start) begin
                    shift_q <= {1'b1, ~^data, data};
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    baud_q  <= '0;
                    bit_q   <= '0;
                end
            end else if (baud_q == BW'(BAUD_DIV - 1)) begin
                baud_q <= '0;
                if (bit_q == 4'd9) begin
                    busy_q <= 1'b0;
                    tx_q   <= 1'b1;
                    done_q <= 1'b1;
                end else begin
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b1, shift_q[8:1]};
                    bit_q   <= bit_q + 4'd1;
                end
            end else begin
                baud_q <= baud_q + BW'(1);
            end
        end
    end

    assign tx   = tx_q;
    assign done = done_q;
endmodule

module exp4_trena #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TRIG_CYCLES   = 500,
    parameter int CYCLES_PER_CM = 2941,
    parameter int BAUD_DIV      = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mensurar,
    input  logic        echo,
    output logic        trigger,
    output logic        saida_serial,
    output logic [6:0]  medida0,
    output logic [6:0]  medida1,
    output logic [6:0]  medida2,
    output logic [11:0] medidatotal,
    output logic        fim_digito,
    output logic        pronto,
    output logic [3:0]  db_estado
);
    localparam int CMAX = (TRIG_CYCLES > CYCLES_PER_CM) ? TRIG_CYCLES : CYCLES_PER_CM;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [3:0] {
        INICIAL = 4'd0, PREPARACAO = 4'd1, ENVIA_TRIGGER = 4'd2, ESPERA_ECHO = 4'd3,
        MEDINDO = 4'd4, ARMAZENA = 4'd5, TRANSMITE = 4'd6, ESPERA_CHAR = 4'd7,
        PROXIMO = 4'd8, FINAL = 4'd9
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cycle_q;
    logic [1:0]    charIdx_q;
    logic [11:0]   medida_q;
    logic [6:0]    seg0_q, seg1_q, seg2_q, charSel;
    logic          mensurar_q, trigger_q, pronto_q, uartStart_q;
    logic          echoLevel, echoRise, bcdClear, bcdInc, uartDone;
    logic [11:0]   bcdValue;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;  4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;  4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;  4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;  4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;  4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    exp4_trena_echo uEcho (.clock(clock), .reset(reset), .echo(echo),
                           .level(echoLevel), .rise(echoRise));

    assign bcdClear = (state_q == PREPARACAO);
    assign bcdInc   = (state_q == MEDINDO) && echoLevel && (cycle_q == CW'(CYCLES_PER_CM - 1));

    exp4_trena_bcd uBcd (.clock(clock), .reset(reset), .clear(bcdClear), .inc(bcdInc),
                         .value(bcdValue));

    always_comb begin
        charSel = 7'h23;
        case (charIdx_q)
            2'd0: charSel = {3'b011, medida_q[11:8]};
            2'd1: charSel = {3'b011, medida_q[7:4]};
            2'd2: charSel = {3'b011, medida_q[3:0]};
            default: charSel = 7'h23;
        endcase
    end

    exp4_trena_uart #(.BAUD_DIV(BAUD_DIV)) uUart (.clock(clock), .reset(reset),
        .start(uartStart_q), .data(charSel), .tx(saida_serial), .done(uartDone));

    // The rising-edge cycle of echo is already counted, hence cycle_q starts at 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= INICIAL;
            cycle_q     <= '0;
            charIdx_q   <= '0;
            medida_q    <= 12'h000;
            seg0_q      <= SEG_ZERO;
            seg1_q      <= SEG_ZERO;
            seg2_q      <= SEG_ZERO;
            mensurar_q  <= 1'b0;
            trigger_q   <= 1'b0;
            pronto_q    <= 1'b0;
            uartStart_q <= 1'b0;
        end else begin
            mensurar_q  <= mensurar;
            pronto_q    <= 1'b0;
            uartStart_q <= 1'b0;
            case (state_q)
                INICIAL: if (mensurar && !mensurar_q) state_q <= PREPARACAO;
                PREPARACAO: begin
                    cycle_q   <= '0;
                    trigger_q <= 1'b1;
                    state_q   <= ENVIA_TRIGGER;
                end
                ENVIA_TRIGGER: begin
                    if (cycle_q == CW'(TRIG_CYCLES - 1)) begin
                        trigger_q <= 1'b0;
                        cycle_q   <= '0;
                        state_q   <= ESPERA_ECHO;
                    end else begin
                        cycle_q <= cycle_q + CW'(1);
                    end
                end
                ESPERA_ECHO: begin
                    if (echoRise) begin
                        cycle_q <= CW'(1);
                        state_q <= MEDINDO;
                    end
                end
                MEDINDO: begin
                    if (!echoLevel)                                  state_q <= ARMAZENA;
                    else if (cycle_q == CW'(CYCLES_PER_CM - 1))      cycle_q <= '0;
                    else                                             cycle_q <= cycle_q + CW'(1);
                end
                ARMAZENA: begin
                    medida_q  <= bcdValue;
                    seg0_q    <= seg7(bcdValue[3:0]);
                    seg1_q    <= seg7(bcdValue[7:4]);
                    seg2_q    <= seg7(bcdValue[11:8]);
                    charIdx_q <= '0;
                    state_q   <= TRANSMITE;
                end
                TRANSMITE: begin
                    uartStart_q <= 1'b1;
                    state_q     <= ESPERA_CHAR;
                end
                ESPERA_CHAR: if (uartDone) state_q <= PROXIMO;
                PROXIMO: begin
                    if (charIdx_q == 2'd3) begin
                        pronto_q <= 1'b1;
                        state_q  <= FINAL;
                    end else begin
                        charIdx_q <= charIdx_q + 2'd1;
                        state_q   <= TRANSMITE;
                    end
                end
                FINAL:   state_q <= INICIAL;
                default: state_q <= INICIAL;
            endcase
        end
    end

    assign trigger     = trigger_q;
    assign pronto      = pronto_q;
    assign fim_digito  = uartDone;
    assign medidatotal = medida_q;
    assign medida0     = seg0_q;
    assign medida1     = seg1_q;
    assign medida2     = seg2_q;
    assign db_estado   = state_q;
endmodule

// File: tb/tb_exp4_trena.sv
// Bench for exp4_trena with shortened timing parameters: random echo widths are checked
// against a centimetre/BCD/ASCII model and a UART line decoder.

module tb_exp4_trena;
    localparam int TRIG = 20;
    localparam int CPC  = 10;
    localparam int BAUD = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mensurar = 1'b0;
    logic        echo = 1'b0;
    logic        trigger, saida_serial, fim_digito, pronto;
    logic [6:0]  medida0, medida1, medida2;
    logic [11:0] medidatotal;
    logic [3:0]  db_estado;

    int checks = 0;
    int failures = 0;
    int trigHigh, trigRise, fimCnt, prCnt;
    logic prevTrig;
    logic [8:0] rxq[$];
    logic [8:0] rxBits;
    logic [6:0] segTable [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    exp4_trena #(.TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .BAUD_DIV(BAUD)) dut (
        .clock(clock), .reset(reset), .mensurar(mensurar), .echo(echo),
        .trigger(trigger), .saida_serial(saida_serial), .medida0(medida0),
        .medida1(medida1), .medida2(medida2), .medidatotal(medidatotal),
        .fim_digito(fim_digito), .pronto(pronto), .db_estado(db_estado));

    always #10 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (trigger === 1'b1) trigHigh++;
        if (trigger === 1'b1 && prevTrig !== 1'b1) trigRise++;
        prevTrig = trigger;
        if (fim_digito === 1'b1) fimCnt++;
        if (pronto === 1'b1) prCnt++;
    endtask

    // UART line decoder: mid-bit sampling, stores {stop, parity, data[6:0]}.
    initial begin
        forever begin
            @(negedge clock);
            if (saida_serial === 1'b0) begin
                repeat (BAUD / 2) @(negedge clock);
                for (int i = 0; i < 9; i++) begin
                    repeat (BAUD) @(negedge clock);
                    rxBits[i] = saida_serial;
                end
                rxq.push_back(rxBits);
            end
        end
    end

    task automatic applyStimulus(input int width, input bit poke);
        int cm, guard, base;
        int h, t, u;
        logic [6:0] chars[4];
        trigHigh = 0; trigRise = 0; fimCnt = 0; prCnt = 0;
        prevTrig = trigger;
        base = rxq.size();
        mensurar = 1'b1;
        repeat (5) tick();
        mensurar = 1'b0;
        guard = 0;
        while ((trigRise == 0 || trigger) && guard < 1000) begin tick(); guard++; end
        checkOutput("trigWait", 32'(guard < 1000), 1);
        repeat (15) tick();
        echo = 1'b1;
        repeat (width) tick();
        echo = 1'b0;
        guard = 0;
        while (prCnt == 0 && guard < 20000) begin
            tick(); guard++;
            if (poke && guard == 40) mensurar = 1'b1;
            if (poke && guard == 43) mensurar = 1'b0;
        end
        checkOutput("prontoWait", 32'(guard < 20000), 1);
        repeat (4) tick();

        cm = width / CPC;
        if (cm > 999) cm = 999;
        h = cm / 100; t = (cm / 10) % 10; u = cm % 10;
        chars[0] = 7'(48 + h); chars[1] = 7'(48 + t); chars[2] = 7'(48 + u); chars[3] = 7'h23;

        checkOutput("trigRises", trigRise, 1);
        checkOutput("trigWidth", trigHigh, TRIG);
        checkOutput("medidatotal", medidatotal, h * 256 + t * 16 + u);
        checkOutput("medida0", medida0, segTable[u]);
        checkOutput("medida1", medida1, segTable[t]);
        checkOutput("medida2", medida2, segTable[h]);
        checkOutput("fimCount", fimCnt, 4);
        checkOutput("prontoCount", prCnt, 1);
        checkOutput("stateIdle", db_estado, 0);
        checkOutput("rxCount", rxq.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            if (base + k < rxq.size()) begin
                checkOutput("rxData", rxq[base + k][6:0], chars[k]);
                checkOutput("rxParityOdd", ^rxq[base + k][7:0], 1);
                checkOutput("rxStop", rxq[base + k][8], 1);
            end
        end
    endtask

    initial begin
        int guard;
        repeat (10) tick();
        reset = 1'b0;
        repeat (50) tick();
        checkOutput("rstTrigger", trigger, 0);
        checkOutput("rstSerial", saida_serial, 1);
        checkOutput("rstMedida", medidatotal, 0);
        checkOutput("rstEstado", db_estado, 0);
        checkOutput("rstSeg0", medida0, 7'b1000000);
        checkOutput("rstPronto", pronto, 0);

        applyStimulus(1000, 1'b0);
        applyStimulus(1009, 1'b0);
        applyStimulus(740, 1'b1);
        applyStimulus(9, 1'b0);
        applyStimulus(10, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(int'($urandom_range(1, 3000)), 1'b0);
        applyStimulus(10005, 1'b0);
        applyStimulus(1234, 1'b0);

        mensurar = 1'b1;
        repeat (3) tick();
        mensurar = 1'b0;
        guard = 0;
        while (db_estado != 4'd3 && guard < 1000) begin tick(); guard++; end
        checkOutput("abortReach", 32'(guard < 1000), 1);
        echo = 1'b1;
        repeat (50) tick();
        reset = 1'b1;
        tick();
        checkOutput("abortEstado", db_estado, 0);
        checkOutput("abortMedida", medidatotal, 0);
        checkOutput("abortSerial", saida_serial, 1);
        checkOutput("abortTrigger", trigger, 0);
        reset = 1'b0;
        echo = 1'b0;
        repeat (10) tick();
        applyStimulus(567, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exp4_trena.md
Name: exp4_trena

Overview:
- Ultrasonic tape-measure controller for an HC-SR04-style sensor, 50 MHz system clock.
- On a measure request it emits a 10 us trigger pulse, then times the echo pulse and converts its width to centimetres as 3 BCD digits.
- It stores the result, drives three 7-segment displays, and transmits the value serially as ASCII "HTU#".
- Top-level block of the experiment; it instantiates its own control FSM, echo interface, BCD counter and UART transmitter.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- TRIG_CYCLES, 500, trigger pulse width in clocks (10 us).
- CYCLES_PER_CM, 2941, clocks of echo per centimetre (58.82 us).
- BAUD_DIV, 434, clocks per serial bit (115200 baud).

Ports:
- clock  in  1  system clock, 50 MHz; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mensurar  in  1  measure request; level, rising edge detected internally.
- echo  in  1  sensor echo; asynchronous, 2-FF synchronised.
- trigger  out  1  sensor trigger pulse.
- saida_serial  out  1  UART TX line, idle high.
- medida0  out  7  units digit, 7-seg active-low, {g,f,e,d,c,b,a}.
- medida1  out  7  tens digit, same encoding.
- medida2  out  7  hundreds digit, same encoding.
- medidatotal  out  12  stored measurement BCD {hundreds,tens,units}.
- fim_digito  out  1  1-cycle pulse at end of each transmitted character.
- pronto  out  1  1-cycle pulse when the full message has been sent.
- db_estado  out  4  current FSM state code.

Behaviour:
- Reset values:
  - trigger=0, saida_serial=1, pronto=0, fim_digito=0.
  - medidatotal=12'h000; medida0..2 show "0" (7'b1000000).
  - db_estado=0.
- FSM states:
  - 0 inicial: waits for a rising edge of mensurar.
  - 1 preparacao: clears the cycle counter and BCD counter; lasts 1 cycle.
  - 2 envia_trigger: trigger=1 for exactly TRIG_CYCLES clocks.
  - 3 espera_echo: waits for a rising edge of synchronised echo.
  - 4 medindo: counts while echo=1; exits on echo falling edge.
  - 5 armazena: loads the BCD count into medidatotal; lasts 1 cycle.
  - 6 transmite: starts a UART character.
  - 7 espera_char: waits for UART done.
  - 8 proximo: advances the character index; returns to 6, or goes to 9 after the 4th character.
  - 9 final: pronto=1 for 1 cycle, then returns to 0.
- mensurar edges outside state 0 are ignored; holding mensurar high gives exactly one measurement.
- Conversion:
  - The cycle counter counts 0..CYCLES_PER_CM-1 while echo is high.
  - On wrap, the 3-digit BCD counter increments.
  - Partial centimetres are truncated.
  - The BCD counter saturates at 999.
- There is no echo timeout; a missing echo holds the FSM in state 3 until reset.
- Display: medida0..2 decode medidatotal[3:0], [7:4], [11:8]. They update only in state 5 and hold otherwise.
- Serial format: 7 data bits LSB first, odd parity, 1 stop bit, BAUD_DIV clocks per bit (10 bits per character).
- Character order: ASCII hundreds (0x30+d), tens, units, then '#' (0x23).
- fim_digito pulses 1 cycle after each character's stop bit completes, 4 pulses per message.
- Synchronous reset in any state aborts the operation: FSM returns to 0, outputs go to reset values, and the UART returns to idle high.

Test Plan:
- Reset 2 us, idle 100 us -> trigger=0, saida_serial=1, medidatotal=000, db_estado=0.
- mensurar high for 5 clocks -> a single trigger pulse of exactly 500 clocks; then echo 400 us later, width 5882 us -> medidatotal=0x100, medida2=1, medida1=0, medida0=0. Serial "1","0","0","#" follows with 4 fim_digito pulses, then pronto.
- Echo width 5899 us -> medidatotal=0x100 (100.29 cm truncated).
- Echo width 4353 us -> medidatotal=0x074; serial bytes 0x30, 0x37, 0x34, 0x23 with correct odd parity.
- mensurar pulse during transmission -> ignored, no second trigger; a new mensurar after pronto starts a new cycle.
- Reset asserted mid-echo -> state 0, medidatotal=000 next cycle, saida_serial=1.
